// File: rtl/ldiv_pkg.sv
// rtl/ldiv_pkg.sv - sizing helpers shared by the ldiv_pipe divider
package ldiv_pkg;

   function automatic int ldiv_stages(input int numerator_width, input int bits_per_stage);
      return numerator_width / bits_per_stage;
   endfunction

   // input register + iteration stages + output register
   function automatic int ldiv_latency(input int numerator_width, input int bits_per_stage);
      return ldiv_stages(numerator_width, bits_per_stage) + 2;
   endfunction

   // valid, tag, num_neg/quo_neg/dbz/ovf, rem (D+1), quotient/numerator (N), |d| (D)
   function automatic int ldiv_state_width(input int numerator_width, input int denominator_width,
                                           input int tag_width);
      return 1 + tag_width + 4 + (denominator_width + 1) + numerator_width + denominator_width;
   endfunction

endpackage

// File: rtl/ldiv_pipe_if.sv
// rtl/ldiv_pipe_if.sv - operand/result handshake bundle for ldiv_pipe
interface ldiv_pipe_if #(
   parameter int NUMERATOR_WIDTH   = 16,
   parameter int DENOMINATOR_WIDTH = 16,
   parameter int TAG_WIDTH         = 8
);
   logic [NUMERATOR_WIDTH-1:0]   numerator_in;
   logic [DENOMINATOR_WIDTH-1:0] denominator_in;
   logic [TAG_WIDTH-1:0]         tag_in;
   logic                         valid_in;
   logic                         ready_in;
   logic [NUMERATOR_WIDTH-1:0]   quotient_out;
   logic [DENOMINATOR_WIDTH-1:0] remainder_out;
   logic [TAG_WIDTH-1:0]         tag_out;
   logic                         div_by_zero_out;
   logic                         overflow_out;
   logic                         valid_out;
   logic                         ready_out;

   modport master (
      output numerator_in, denominator_in, tag_in, valid_in, ready_out,
      input  ready_in, quotient_out, remainder_out, tag_out, div_by_zero_out, overflow_out, valid_out
   );

   modport slave (
      input  numerator_in, denominator_in, tag_in, valid_in, ready_out,
      output ready_in, quotient_out, remainder_out, tag_out, div_by_zero_out, overflow_out, valid_out
   );
endinterface

// File: rtl/ldiv_pipe_stage.sv
// rtl/ldiv_pipe_stage.sv - one register stage of BITS_PER_STAGE restoring division steps
module ldiv_pipe_stage
   import ldiv_pkg::*;
#(
   parameter int NUMERATOR_WIDTH   = 16,
   parameter int DENOMINATOR_WIDTH = 16,
   parameter int TAG_WIDTH         = 8,
   parameter int BITS_PER_STAGE    = 1
) (
   input  logic clk,
   input  logic reset,
   input  logic en_i,
   input  logic [ldiv_state_width(NUMERATOR_WIDTH, DENOMINATOR_WIDTH, TAG_WIDTH)-1:0] state_i,
   output logic [ldiv_state_width(NUMERATOR_WIDTH, DENOMINATOR_WIDTH, TAG_WIDTH)-1:0] state_o
);
   typedef struct packed {
      logic                         valid;
      logic [TAG_WIDTH-1:0]         tag;
      logic                         num_neg;
      logic                         quo_neg;
      logic                         dbz;
      logic                         ovf;
      logic [DENOMINATOR_WIDTH:0]   rem;
      logic [NUMERATOR_WIDTH-1:0]   qn;
      logic [DENOMINATOR_WIDTH-1:0] dabs;
   } state_t;

   state_t state_d, state_q;

   // qn shifts numerator bits out of the top while quotient bits enter at the bottom
   always_comb begin
      state_d = state_i;
      for (int b = 0; b < BITS_PER_STAGE; b++) begin
         state_d.rem = {state_d.rem[DENOMINATOR_WIDTH-1:0], state_d.qn[NUMERATOR_WIDTH-1]};
         state_d.qn  = {state_d.qn[NUMERATOR_WIDTH-2:0], 1'b0};
         if (state_d.rem >= {1'b0, state_d.dabs}) begin
            state_d.rem   = state_d.rem - {1'b0, state_d.dabs};
            state_d.qn[0] = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q <= '0;
      end else if (en_i) begin
         state_q <= state_d;
      end
   end

   assign state_o = state_q;
endmodule

// File: rtl/ldiv_pipe.sv
// rtl/ldiv_pipe.sv - fully pipelined signed divider, one result per clock under a global stall
module ldiv_pipe
   import ldiv_pkg::*;
#(
   parameter int NUMERATOR_WIDTH   = 16,
   parameter int DENOMINATOR_WIDTH = 16,
   parameter int BITS_PER_STAGE    = 1,
   parameter int TAG_WIDTH         = 8
) (
   input logic        clk,
   input logic        reset,
   ldiv_pipe_if.slave bus
);
   localparam int NW      = NUMERATOR_WIDTH;
   localparam int DW      = DENOMINATOR_WIDTH;
   localparam int STAGES  = ldiv_stages(NW, BITS_PER_STAGE);
   localparam int STATE_W = ldiv_state_width(NW, DW, TAG_WIDTH);
   localparam logic [NW-1:0] NUM_MIN = {1'b1, {(NW-1){1'b0}}};

   if (NUMERATOR_WIDTH % BITS_PER_STAGE != 0) begin : g_bad_bits_per_stage
      $error("ldiv_pipe: BITS_PER_STAGE must divide NUMERATOR_WIDTH");
   end

   typedef struct packed {
      logic                 valid;
      logic [TAG_WIDTH-1:0] tag;
      logic                 num_neg;
      logic                 quo_neg;
      logic                 dbz;
      logic                 ovf;
      logic [DW:0]          rem;
      logic [NW-1:0]        qn;
      logic [DW-1:0]        dabs;
   } state_t;

   logic               advance;
   state_t             in_d, in_q, last;
   logic [STATE_W-1:0] pipe [STAGES+1];

   logic [NW-1:0]        quotient_d, quotient_q;
   logic [DW-1:0]        remainder_d, remainder_q;
   logic [TAG_WIDTH-1:0] tag_q;
   logic                 valid_q, dbz_q, ovf_q;
   logic                 unused_rem_msb;

   assign advance      = !valid_q || bus.ready_out;
   assign bus.ready_in = advance;

   // On divide-by-zero |d| is meaningless, so dabs carries the sign-adjusted numerator
   // through to become the remainder.
   always_comb begin
      in_d         = '0;
      in_d.valid   = bus.valid_in;
      in_d.tag     = bus.tag_in;
      in_d.num_neg = bus.numerator_in[NW-1];
      in_d.quo_neg = bus.numerator_in[NW-1] ^ bus.denominator_in[DW-1];
      in_d.dbz     = (bus.denominator_in == '0);
      in_d.ovf     = (bus.numerator_in == NUM_MIN) && (bus.denominator_in == '1);
      in_d.qn      = bus.numerator_in[NW-1] ? -bus.numerator_in : bus.numerator_in;
      if (in_d.dbz) begin
         in_d.dabs = DW'($signed(bus.numerator_in));
      end else begin
         in_d.dabs = bus.denominator_in[DW-1] ? -bus.denominator_in : bus.denominator_in;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         in_q <= '0;
      end else if (advance) begin
         in_q <= in_d;
      end
   end

   assign pipe[0] = in_q;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      ldiv_pipe_stage #(
         .NUMERATOR_WIDTH  (NW),
         .DENOMINATOR_WIDTH(DW),
         .TAG_WIDTH        (TAG_WIDTH),
         .BITS_PER_STAGE   (BITS_PER_STAGE)
      ) u_stage (
         .clk    (clk),
         .reset  (reset),
         .en_i   (advance),
         .state_i(pipe[k]),
         .state_o(pipe[k+1])
      );
   end

   assign last           = pipe[STAGES];
   assign unused_rem_msb = last.rem[DW];

   always_comb begin
      quotient_d  = last.quo_neg ? -last.qn : last.qn;
      remainder_d = last.num_neg ? -last.rem[DW-1:0] : last.rem[DW-1:0];
      if (last.dbz) begin
         quotient_d  = '1;
         remainder_d = last.dabs;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         valid_q     <= 1'b0;
         tag_q       <= '0;
         dbz_q       <= 1'b0;
         ovf_q       <= 1'b0;
         quotient_q  <= '0;
         remainder_q <= '0;
      end else if (advance) begin
         valid_q     <= last.valid;
         tag_q       <= last.tag;
         dbz_q       <= last.valid && last.dbz;
         ovf_q       <= last.valid && last.ovf;
         quotient_q  <= quotient_d;
         remainder_q <= remainder_d;
      end
   end

   assign bus.valid_out       = valid_q;
   assign bus.tag_out         = tag_q;
   assign bus.div_by_zero_out = dbz_q;
   assign bus.overflow_out    = ovf_q;
   assign bus.quotient_out    = quotient_q;
   assign bus.remainder_out   = remainder_q;
endmodule
